// File: rtl/switch_debounce_led_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_led_if
// Description : Signal bundle between the raw push-switch pins and the LED
//               drivers of switch_debounce_led.
//               master : drives the raw switches, observes the LEDs
//               slave  : the debouncer; samples switches, drives LEDs
//   i_switch_1/2 : raw switch levels, asynchronous, active-high when pressed
//   o_led_1/2    : release-toggle LEDs (registered)
//   o_led_3      : debounced switch 1 AND switch 2
//   o_led_4      : debounced switch 1 OR switch 2
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_debounce_led_if;
  logic i_switch_1;
  logic i_switch_2;
  logic o_led_1;
  logic o_led_2;
  logic o_led_3;
  logic o_led_4;

  modport master (
    output i_switch_1,
    output i_switch_2,
    input  o_led_1,
    input  o_led_2,
    input  o_led_3,
    input  o_led_4
  );

  modport slave (
    input  i_switch_1,
    input  i_switch_2,
    output o_led_1,
    output o_led_2,
    output o_led_3,
    output o_led_4
  );
endinterface
`default_nettype wire

// File: rtl/switch_debounce_led.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_led
// Description : Two-channel switch front end. Each raw switch is passed
//               through a 2-flop synchroniser and a stability counter; a
//               level change is accepted only after DEBOUNCE_CYCLES
//               consecutive clocks of disagreement with the current stable
//               level. Debounced releases toggle o_led_1/o_led_2; the stable
//               levels are combined into AND (o_led_3) and OR (o_led_4).
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset; release must be synchronous
//             to i_clk (supplied by the board reset synchroniser)
//   bus     : slave side of switch_debounce_led_if (switches in, LEDs out)
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce_led #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  switch_debounce_led_if.slave  bus
);

  // Counter value on which the pending level change is committed.
  localparam logic [CNT_W-1:0] c_TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] w_raw;
  logic [1:0] w_stable;
  logic [1:0] w_led;

  assign w_raw = {bus.i_switch_2, bus.i_switch_1};

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic             led_q;
    logic             w_release;

    // Any disagreement run that is broken before terminal count restarts
    // from zero, so only DEBOUNCE_CYCLES uninterrupted clocks can commit.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_TERM_CNT) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // One-cycle pulse on the falling edge of the stable level only.
    assign w_release = stable_prev_q & ~stable_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync1_q       <= 1'b0;
        sync2_q       <= 1'b0;
        cnt_q         <= '0;
        stable_q      <= 1'b0;
        stable_prev_q <= 1'b0;
        led_q         <= 1'b0;
      end else begin
        sync1_q       <= w_raw[c];
        sync2_q       <= sync1_q;
        cnt_q         <= cnt_d;
        stable_q      <= stable_d;
        stable_prev_q <= stable_q;
        if (w_release) begin
          led_q <= ~led_q;
        end
      end
    end

    assign w_stable[c] = stable_q;
    assign w_led[c]    = led_q;
  end

  assign bus.o_led_1 = w_led[0];
  assign bus.o_led_2 = w_led[1];
  // Level LEDs come only from the debounced registers, never the raw pins.
  assign bus.o_led_3 = w_stable[0] & w_stable[1];
  assign bus.o_led_4 = w_stable[0] | w_stable[1];

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_led.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce_led
// Description : Self-checking bench for switch_debounce_led with
//               DEBOUNCE_CYCLES=4. A sliding-window model (a level is
//               accepted once the last D synchronised samples all disagree
//               with it) is compared with the LEDs every cycle; directed
//               literal checks pin latencies and boundary cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce_led;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  switch_debounce_led_if bus ();

  switch_debounce_led #(.DEBOUNCE_CYCLES(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist[c][i] is the raw level sampled i+1 edges ago. The synchronised
  // level seen at an edge is two samples old, so the D samples that decide
  // the edge are m_hist[c][1..D].
  bit m_hist   [2][D+1];
  bit m_stable [2];
  bit m_fell   [2];
  bit m_led    [2];

  always @(posedge clk) begin
    bit raw [2];
    bit all_new;
    raw[0] = bus.i_switch_1;
    raw[1] = bus.i_switch_2;
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        for (int i = 0; i <= D; i++) m_hist[c][i] = 1'b0;
        m_stable[c] = 1'b0;
        m_fell[c]   = 1'b0;
        m_led[c]    = 1'b0;
      end else begin
        if (m_fell[c]) m_led[c] = ~m_led[c];
        m_fell[c] = 1'b0;
        all_new = 1'b1;
        for (int i = 1; i <= D; i++)
          if (m_hist[c][i] == m_stable[c]) all_new = 1'b0;
        if (all_new) begin
          if (m_stable[c]) m_fell[c] = 1'b1;
          m_stable[c] = ~m_stable[c];
        end
        for (int i = D; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
        m_hist[c][0] = raw[c];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    check("cyc_led1", bus.o_led_1, rst_n ? m_led[0] : 1'b0);
    check("cyc_led2", bus.o_led_2, rst_n ? m_led[1] : 1'b0);
    check("cyc_led3", bus.o_led_3, rst_n ? (m_stable[0] & m_stable[1]) : 1'b0);
    check("cyc_led4", bus.o_led_4, rst_n ? (m_stable[0] | m_stable[1]) : 1'b0);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_led1"}, bus.o_led_1, 1'b0);
    check({name, "_led2"}, bus.o_led_2, 1'b0);
    check({name, "_led3"}, bus.o_led_3, 1'b0);
    check({name, "_led4"}, bus.o_led_4, 1'b0);
  endtask

  // Called on a falling clock edge; holds reset for three rising edges.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check_all_zero(name);
    wait_neg(3);
    rst_n = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b1;
    bus.i_switch_1 = 1'b0;
    bus.i_switch_2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t1_in_reset");
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(1);
    check_all_zero("t1_after_reset");

    // Clean press / release of switch 1.
    bus.i_switch_1 = 1'b1;
    wait_neg(5);
    check("t2_led4_edge5", bus.o_led_4, 1'b0);
    wait_neg(1);
    check("t2_led4_edge6", bus.o_led_4, 1'b1);
    wait_neg(14);
    check("t2_led3_held", bus.o_led_3, 1'b0);
    bus.i_switch_1 = 1'b0;
    wait_neg(6);
    check("t2_led1_edge6", bus.o_led_1, 1'b0);
    check("t2_led4_fell", bus.o_led_4, 1'b0);
    wait_neg(1);
    check("t2_led1_edge7", bus.o_led_1, 1'b1);
    wait_neg(3);

    // Bouncing switch 2, then a clean hold.
    bus.i_switch_2 = 1'b1; wait_neg(1);
    bus.i_switch_2 = 1'b0; wait_neg(1);
    bus.i_switch_2 = 1'b1; wait_neg(1);
    bus.i_switch_2 = 1'b0; wait_neg(1);
    bus.i_switch_2 = 1'b1;
    wait_neg(5);
    check("t3_led4_edge5", bus.o_led_4, 1'b0);
    wait_neg(1);
    check("t3_led4_edge6", bus.o_led_4, 1'b1);
    wait_neg(4);
    bus.i_switch_2 = 1'b0;
    wait_neg(7);
    check("t3_led2_toggled", bus.o_led_2, 1'b1);
    wait_neg(3);

    // Glitch on switch 1 one cycle shorter than the debounce window.
    bus.i_switch_1 = 1'b1;
    wait_neg(3);
    bus.i_switch_1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_neg(1);
      check("t4_led4_steady", bus.o_led_4, 1'b0);
      check("t4_led1_steady", bus.o_led_1, 1'b1);
    end

    // Both channels together, starting from cleared toggles.
    do_reset("t5_reset");
    wait_neg(1);
    bus.i_switch_1 = 1'b1;
    bus.i_switch_2 = 1'b1;
    wait_neg(10);
    check("t5_led3_held", bus.o_led_3, 1'b1);
    check("t5_led4_held", bus.o_led_4, 1'b1);
    bus.i_switch_1 = 1'b0;
    bus.i_switch_2 = 1'b0;
    wait_neg(6);
    check("t5_led1_edge6", bus.o_led_1, 1'b0);
    check("t5_led2_edge6", bus.o_led_2, 1'b0);
    wait_neg(1);
    check("t5_led1_edge7", bus.o_led_1, 1'b1);
    check("t5_led2_edge7", bus.o_led_2, 1'b1);
    wait_neg(3);
    bus.i_switch_1 = 1'b1;
    bus.i_switch_2 = 1'b1;
    wait_neg(10);
    bus.i_switch_1 = 1'b0;
    bus.i_switch_2 = 1'b0;
    wait_neg(7);
    check("t5_led1_second", bus.o_led_1, 1'b0);
    check("t5_led2_second", bus.o_led_2, 1'b0);
    wait_neg(3);

    // Reset in the middle of a debounce with switch 1 held.
    bus.i_switch_1 = 1'b1;
    wait_neg(4);
    do_reset("t6_reset");
    wait_neg(5);
    check("t6_led4_edge5", bus.o_led_4, 1'b0);
    wait_neg(1);
    check("t6_led4_edge6", bus.o_led_4, 1'b1);
    check("t6_led1_no_toggle", bus.o_led_1, 1'b0);
    wait_neg(3);
    check("t6_led1_still", bus.o_led_1, 1'b0);
    bus.i_switch_1 = 1'b0;
    wait_neg(7);
    check("t6_led1_release", bus.o_led_1, 1'b1);
    wait_neg(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
